// File: rtl/ucaspian_step_ctrl.sv
// Time-step scheduler for uCaspian: issues next_step, waits for all units, and sequences clears.
// Optional WAIT watchdog enabled by defining UCASPIAN_STEP_TIMEOUT_EN.
module ucaspian_step_ctrl #(
    parameter int NUM_UNITS  = 3,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 2
`ifdef UCASPIAN_STEP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_W-1:0]     cmd_steps,
    input  logic                 cmd_run_vld,
    output logic                 cmd_run_rdy,
    input  logic                 cmd_clear_act,
    input  logic                 cmd_clear_config,
    input  logic [NUM_UNITS-1:0] unit_step_done,
    input  logic [NUM_UNITS-1:0] unit_clear_done,
    output logic                 next_step,
    output logic                 clear_act,
    output logic                 clear_config,
    output logic [CNT_W-1:0]     step_count,
    output logic                 run_done,
    output logic                 busy,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, SETTLE, WAIT, DONE} state_t;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   step_count_d, step_inc;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               next_step_d, clear_act_d, clear_config_d;
    logic               run_done_d, busy_d, timeout_d;
    logic               clr_req, clr_new;

`ifdef UCASPIAN_STEP_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    assign clr_req     = cmd_clear_act | cmd_clear_config;
    assign clr_new     = (cmd_clear_act & ~clear_act) | (cmd_clear_config & ~clear_config);
    assign step_inc    = step_count + CNT_W'(1);
    assign cmd_run_rdy = (state_q == IDLE) && !clr_req;

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        step_count_d   = step_count;
        settle_d       = settle_q;
        next_step_d    = 1'b0;
        clear_act_d    = clear_act;
        clear_config_d = clear_config;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
        timeout_d      = timeout_err;
        to_cnt_d       = to_cnt_q;
`else
        timeout_d      = 1'b0;
`endif
        // A clear during an active run aborts it; a pulse already on the wire stays issued.
        if ((state_q == ISSUE || state_q == SETTLE || state_q == WAIT) && clr_req) begin
            state_d        = CLEAR;
            clear_act_d    = cmd_clear_act;
            clear_config_d = cmd_clear_config;
            step_count_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_d        = CLEAR;
                        clear_act_d    = cmd_clear_act;
                        clear_config_d = cmd_clear_config;
                        step_count_d   = '0;
                    end else if (cmd_run_vld) begin
                        target_d     = cmd_steps;
                        step_count_d = '0;
                        if (cmd_steps == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d     = ISSUE;
                            next_step_d = enable;
                        end
                    end
                end
                CLEAR: begin
                    clear_act_d    = clear_act | cmd_clear_act;
                    clear_config_d = clear_config | cmd_clear_config;
                    step_count_d   = '0;
                    // Stay one more round if a fresh clear kind shows up on the exit cycle.
                    if ((&unit_clear_done) && !clr_new) begin
                        state_d        = IDLE;
                        clear_act_d    = 1'b0;
                        clear_config_d = 1'b0;
                    end
                end
                ISSUE: begin
                    if (next_step) begin
                        settle_d = '0;
                        if (SETTLE_CYC == 0) begin
                            state_d = WAIT;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
                            to_cnt_d = '0;
`endif
                        end else begin
                            state_d = SETTLE;
                        end
                    end else if (enable) begin
                        next_step_d = 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = WAIT;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                WAIT: begin
                    if ((&unit_step_done) && enable) begin
                        step_count_d = step_inc;
                        if (step_inc == target_q) begin
                            state_d = DONE;
                        end else begin
                            state_d     = ISSUE;
                            next_step_d = 1'b1;
                        end
                    end else begin
`ifdef UCASPIAN_STEP_TIMEOUT_EN
                        if (to_cnt_q == TO_LAST) begin
                            timeout_d = 1'b1;
                            state_d   = DONE;
                        end else begin
                            to_cnt_d = to_cnt_q + TO_W'(1);
                        end
`endif
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
`ifdef UCASPIAN_STEP_TIMEOUT_EN
        if (state_d == CLEAR && clear_config_d) begin
            timeout_d = 1'b0;
        end
`endif
        run_done_d = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            target_q     <= '0;
            step_count   <= '0;
            settle_q     <= '0;
            next_step    <= 1'b0;
            clear_act    <= 1'b0;
            clear_config <= 1'b0;
            run_done     <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            step_count   <= step_count_d;
            settle_q     <= settle_d;
            next_step    <= next_step_d;
            clear_act    <= clear_act_d;
            clear_config <= clear_config_d;
            run_done     <= run_done_d;
            busy         <= busy_d;
            timeout_err  <= timeout_d;
`ifdef UCASPIAN_STEP_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

endmodule
